// File: rtl/ase_local_mem_avmm_tester.sv
// Avalon-MM local-memory tester: writes num_bursts seeded bursts, reads them back, counts bad beats.
// Optional macro ASE_LOCAL_MEM_TESTER_STOP_ON_ERR_EN: end the test after the burst holding the first mismatch.
module ase_local_mem_avmm_tester #(
  parameter int ADDR_WIDTH      = 27,
  parameter int DATA_WIDTH      = 512,
  parameter int BURST_CNT_WIDTH = 7,
  parameter int BURST_LEN       = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [15:0]                num_bursts,
  input  logic [ADDR_WIDTH-1:0]      base_addr,
  input  logic [31:0]                seed,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [15:0]                err_count,
  output logic [ADDR_WIDTH-1:0]      avm_address,
  output logic [BURST_CNT_WIDTH-1:0] avm_burstcount,
  output logic                       avm_write,
  output logic                       avm_read,
  output logic [DATA_WIDTH-1:0]      avm_writedata,
  output logic [DATA_WIDTH/8-1:0]    avm_byteenable,
  input  logic                       avm_waitrequest,
  input  logic [DATA_WIDTH-1:0]      avm_readdata,
  input  logic                       avm_readdatavalid
);

`ifdef ASE_LOCAL_MEM_TESTER_STOP_ON_ERR_EN
  localparam bit STOP_ON_ERR = 1'b1;
`else
  localparam bit STOP_ON_ERR = 1'b0;
`endif

  localparam logic [BURST_CNT_WIDTH-1:0] BURST_CNT = BURST_CNT_WIDTH'(BURST_LEN);
  localparam logic [BURST_CNT_WIDTH-1:0] LAST_BEAT = BURST_CNT_WIDTH'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0]      ADDR_STEP = ADDR_WIDTH'(BURST_LEN);

  typedef enum logic [2:0] {IDLE, WR, RD_CMD, RD_DATA, FIN} state_e;

  function automatic logic [DATA_WIDTH-1:0] beat_pattern(input logic [31:0] g,
                                                         input logic [31:0] s);
    logic [DATA_WIDTH-1:0] p;
    for (int i = 0; i < DATA_WIDTH/32; i++) p[32*i +: 32] = g ^ s;
    return p;
  endfunction

  state_e                     state_q, state_d;
  logic [15:0]                burst_q, burst_d;
  logic [BURST_CNT_WIDTH-1:0] beat_q, beat_d;
  logic [31:0]                g_q, g_d;
  logic [15:0]                num_bursts_q, num_bursts_d;
  logic [ADDR_WIDTH-1:0]      base_q, base_d;
  logic [31:0]                seed_q, seed_d;
  logic [15:0]                err_q, err_d;
  logic                       pass_q, pass_d;
  logic                       done_q, done_d;
  logic                       busy_q, busy_d;
  logic                       stop_q, stop_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [BURST_CNT_WIDTH-1:0] bcnt_q, bcnt_d;
  logic                       write_q, write_d;
  logic                       read_q, read_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;

  logic        last_beat, last_burst, mismatch, unexpected, enter_fin, clear_err;
  logic [15:0] err_base;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    burst_d      = burst_q;
    beat_d       = beat_q;
    g_d          = g_q;
    num_bursts_d = num_bursts_q;
    base_d       = base_q;
    seed_d       = seed_q;
    pass_d       = pass_q;
    done_d       = 1'b0;
    busy_d       = busy_q;
    stop_d       = stop_q;
    addr_d       = addr_q;
    bcnt_d       = bcnt_q;
    write_d      = write_q;
    read_d       = read_q;
    wdata_d      = wdata_q;
    mismatch     = 1'b0;
    enter_fin    = 1'b0;
    clear_err    = 1'b0;
    last_beat    = (beat_q == LAST_BEAT);
    last_burst   = (burst_q == num_bursts_q - 16'd1);
    unexpected   = avm_readdatavalid && (state_q != RD_DATA);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          num_bursts_d = num_bursts;
          base_d       = base_addr;
          seed_d       = seed;
          burst_d      = '0;
          beat_d       = '0;
          g_d          = '0;
          stop_d       = 1'b0;
          pass_d       = 1'b0;
          clear_err    = 1'b1;
          if (num_bursts == 16'd0) begin
            enter_fin = 1'b1;
          end else begin
            state_d = WR;
            busy_d  = 1'b1;
            write_d = 1'b1;
            addr_d  = base_addr;
            bcnt_d  = BURST_CNT;
            wdata_d = beat_pattern(32'd0, seed);
          end
        end
      end
      WR: begin
        if (!avm_waitrequest) begin
          g_d     = g_q + 32'd1;
          wdata_d = beat_pattern(g_q + 32'd1, seed_q);
          if (last_beat) begin
            beat_d = '0;
            if (last_burst) begin
              // Reads replay the same address sequence with the beat index restarted.
              state_d = RD_CMD;
              write_d = 1'b0;
              read_d  = 1'b1;
              addr_d  = base_q;
              burst_d = '0;
              g_d     = '0;
            end else begin
              burst_d = burst_q + 16'd1;
              addr_d  = addr_q + ADDR_STEP;
            end
          end else begin
            beat_d = beat_q + BURST_CNT_WIDTH'(1);
          end
        end
      end
      RD_CMD: begin
        if (!avm_waitrequest) begin
          state_d = RD_DATA;
          read_d  = 1'b0;
          beat_d  = '0;
        end
      end
      RD_DATA: begin
        if (avm_readdatavalid) begin
          g_d      = g_q + 32'd1;
          mismatch = (avm_readdata != beat_pattern(g_q, seed_q));
          if (STOP_ON_ERR && mismatch) stop_d = 1'b1;
          if (last_beat) begin
            beat_d = '0;
            if (last_burst || (STOP_ON_ERR && (stop_q || mismatch))) begin
              enter_fin = 1'b1;
            end else begin
              state_d = RD_CMD;
              read_d  = 1'b1;
              burst_d = burst_q + 16'd1;
              addr_d  = addr_q + ADDR_STEP;
            end
          end else begin
            beat_d = beat_q + BURST_CNT_WIDTH'(1);
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    err_base = clear_err ? 16'd0 : err_q;
    err_d    = ((mismatch || unexpected) && (err_base != 16'hFFFF)) ? err_base + 16'd1
                                                                     : err_base;
    if (enter_fin) begin
      state_d = FIN;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      pass_d  = (err_d == 16'd0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; every flop, including the
  // wide writedata register, is cleared by the asynchronous reset so outputs are defined at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      burst_q      <= '0;
      beat_q       <= '0;
      g_q          <= '0;
      num_bursts_q <= '0;
      base_q       <= '0;
      seed_q       <= '0;
      err_q        <= '0;
      pass_q       <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      stop_q       <= 1'b0;
      addr_q       <= '0;
      bcnt_q       <= '0;
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      burst_q      <= burst_d;
      beat_q       <= beat_d;
      g_q          <= g_d;
      num_bursts_q <= num_bursts_d;
      base_q       <= base_d;
      seed_q       <= seed_d;
      err_q        <= err_d;
      pass_q       <= pass_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      stop_q       <= stop_d;
      addr_q       <= addr_d;
      bcnt_q       <= bcnt_d;
      write_q      <= write_d;
      read_q       <= read_d;
      wdata_q      <= wdata_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign avm_address    = addr_q;
  assign avm_burstcount = bcnt_q;
  assign avm_write      = write_q;
  assign avm_read       = read_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = '1;

endmodule

// File: tb/tb_ase_local_mem_avmm_tester.sv
// Bench for ase_local_mem_avmm_tester: memory model with a scoreboard of expected write/read commands.
module tb_ase_local_mem_avmm_tester;
  localparam int AW = 27, DW = 512, BCW = 7, BL = 4;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic [15:0] num_bursts = '0;
  logic [AW-1:0] base_addr = '0;
  logic [31:0] seed = '0;
  logic busy, done, pass;
  logic [15:0] err_count;
  logic [AW-1:0] avm_address;
  logic [BCW-1:0] avm_burstcount;
  logic avm_write, avm_read;
  logic [DW-1:0] avm_writedata;
  logic [DW/8-1:0] avm_byteenable;
  logic avm_waitrequest = 1'b0;
  logic [DW-1:0] avm_readdata = '0;
  logic avm_readdatavalid = 1'b0;

  ase_local_mem_avmm_tester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BCW),
                              .BURST_LEN(BL)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_bursts(num_bursts),
    .base_addr(base_addr), .seed(seed), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .avm_address(avm_address), .avm_burstcount(avm_burstcount),
    .avm_write(avm_write), .avm_read(avm_read), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int total = 0, bad = 0;
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_pattern(input logic [31:0] g, input logic [31:0] s);
    logic [DW-1:0] p;
    for (int i = 0; i < DW/32; i++) p[32*i +: 32] = g ^ s;
    return p;
  endfunction

  // Scoreboard and memory model state
  logic [AW-1:0] exp_wr_addr[$];
  logic [DW-1:0] exp_wr_data[$];
  logic [AW-1:0] exp_rd_addr[$];
  logic [DW-1:0] rd_pend[$];
  logic [DW-1:0] mem[logic [AW-1:0]];
  bit stall_en = 0, inject = 0, prev_stall = 0;
  int flip_beat = -1, rd_idx = 0, wr_off = 0, n_wr = 0, n_rd_cmd = 0;
  int first_wr_cyc = -1, last_wr_cyc = -1, last_rd_cyc = -1;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  initial begin
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;
        prev_stall        = 0;
        continue;
      end
      if (inject) begin
        inject            = 0;
        avm_readdata      = '0;
        avm_readdatavalid = 1'b1;
      end else if (rd_pend.size() > 0) begin
        d = rd_pend.pop_front();
        if (rd_idx == flip_beat) d[0] = ~d[0];
        rd_idx++;
        last_rd_cyc       = cyc;
        avm_readdata      = d;
        avm_readdatavalid = 1'b1;
      end else begin
        avm_readdatavalid = 1'b0;
      end
      avm_waitrequest = stall_en && ($urandom_range(0, 3) == 0);
      if (avm_write || avm_read)
        check("wr_rd_exclusive", DW'(avm_write & avm_read), '0);
      if (prev_stall) begin
        check("stall_write_held", DW'(avm_write), DW'(1));
        check("stall_addr_held", DW'(avm_address), DW'(prev_addr));
        check("stall_data_held", avm_writedata, prev_data);
      end
      if (avm_write && first_wr_cyc < 0) first_wr_cyc = cyc;
      if (avm_write && !avm_waitrequest) begin
        if (exp_wr_addr.size() == 0) begin
          check("wr_unexpected", DW'(1), DW'(0));
        end else begin
          check("wr_addr", DW'(avm_address), DW'(exp_wr_addr.pop_front()));
          check("wr_data", avm_writedata, exp_wr_data.pop_front());
        end
        check("wr_burstcount", DW'(avm_burstcount), DW'(BL));
        check("wr_byteenable", DW'(avm_byteenable), DW'({(DW/8){1'b1}}));
        a = avm_address + AW'(wr_off);
        mem[a] = avm_writedata;
        wr_off = (wr_off + 1) % BL;
        n_wr++;
        last_wr_cyc = cyc;
      end
      if (avm_read && !avm_waitrequest) begin
        if (exp_rd_addr.size() == 0) check("rd_unexpected", DW'(1), DW'(0));
        else check("rd_addr", DW'(avm_address), DW'(exp_rd_addr.pop_front()));
        check("rd_burstcount", DW'(avm_burstcount), DW'(BL));
        for (int i = 0; i < BL; i++) begin
          a = avm_address + AW'(i);
          rd_pend.push_back(mem.exists(a) ? mem[a] : '0);
        end
        n_rd_cmd++;
      end
      prev_stall = avm_write && avm_waitrequest;
      prev_addr  = avm_address;
      prev_data  = avm_writedata;
    end
  end

  // Pushes the expected command stream for one test; returns how many read bursts to expect.
  task automatic prime(input int nb, input logic [AW-1:0] base, input logic [31:0] sd,
                       input int flip, output int n_rd_exp);
    logic [AW-1:0] a;
    n_rd_exp = nb;
`ifdef ASE_LOCAL_MEM_TESTER_STOP_ON_ERR_EN
    if (flip >= 0 && flip < nb*BL) n_rd_exp = flip/BL + 1;
`endif
    exp_wr_addr.delete(); exp_wr_data.delete(); exp_rd_addr.delete(); rd_pend.delete();
    for (int k = 0; k < nb; k++) begin
      a = base + AW'(k*BL);
      for (int b = 0; b < BL; b++) begin
        exp_wr_addr.push_back(a);
        exp_wr_data.push_back(exp_pattern(32'(k*BL + b), sd));
      end
      if (k < n_rd_exp) exp_rd_addr.push_back(a);
    end
    n_wr = 0; n_rd_cmd = 0; rd_idx = 0; wr_off = 0;
    first_wr_cyc = -1; last_wr_cyc = -1; last_rd_cyc = -1;
    flip_beat = flip;
  endtask

  task automatic launch(input int nb, input logic [AW-1:0] base, input logic [31:0] sd,
                        output int start_cyc);
    @(negedge clk);
    start = 1'b1; num_bursts = 16'(nb); base_addr = base; seed = sd;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_test(input int nb, input logic [AW-1:0] base, input logic [31:0] sd,
                          input bit stall, input int flip, input int exp_err);
    int n_rd_exp, start_cyc, done_cyc;
    prime(nb, base, sd, flip, n_rd_exp);
    stall_en = stall;
    launch(nb, base, sd, start_cyc);
    done_cyc = -1;
    for (int i = 0; i < 4000 && done_cyc < 0; i++) begin
      if (done) done_cyc = cyc;
      else @(negedge clk);
    end
    if (done_cyc < 0) begin
      check("done_timeout", DW'(0), DW'(1));
    end else begin
      check("err_count", DW'(err_count), DW'(exp_err));
      check("pass", DW'(pass), DW'(exp_err == 0));
      check("busy_at_done", DW'(busy), DW'(0));
      check("n_write_beats", DW'(n_wr), DW'(nb*BL));
      check("n_read_cmds", DW'(n_rd_cmd), DW'(n_rd_exp));
      check("wr_queue_left", DW'(exp_wr_addr.size()), DW'(0));
      if (nb > 0) begin
        check("write_latency", DW'(first_wr_cyc), DW'(start_cyc + 1));
        check("done_latency", DW'(done_cyc), DW'(last_rd_cyc + 1));
        if (!stall) check("write_back_to_back", DW'(last_wr_cyc - first_wr_cyc), DW'(nb*BL - 1));
      end else begin
        check("done_latency_zero", DW'(done_cyc), DW'(start_cyc + 1));
      end
      @(negedge clk);
      check("done_one_cycle", DW'(done), DW'(0));
      check("pass_held", DW'(pass), DW'(exp_err == 0));
    end
    stall_en = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, DW'(busy), DW'(0));
    check({tag, "_done"}, DW'(done), DW'(0));
    check({tag, "_pass"}, DW'(pass), DW'(0));
    check({tag, "_write"}, DW'(avm_write), DW'(0));
    check({tag, "_read"}, DW'(avm_read), DW'(0));
    check({tag, "_err"}, DW'(err_count), DW'(0));
    check({tag, "_addr"}, DW'(avm_address), DW'(0));
    check({tag, "_bcnt"}, DW'(avm_burstcount), DW'(0));
  endtask

  initial begin
    int n_rd_exp, start_cyc;
    #1;
    check_reset_state("por");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run_test(3, AW'(32'h100), 32'hA5A5A5A5, 0, -1, 0);
    run_test(3, AW'(32'h300), 32'h12345678, 1, -1, 0);
    run_test(3, AW'(32'h40), 32'hDEADBEEF, 0, 5, 1);

    // Reset in the middle of the write phase
    prime(3, AW'(32'h500), 32'h0BADF00D, -1, n_rd_exp);
    launch(3, AW'(32'h500), 32'h0BADF00D, start_cyc);
    repeat (2) @(negedge clk);
    check("pre_reset_write", DW'(avm_write), DW'(1));
    #2 reset_n = 1'b0;
    #1 check_reset_state("mid_wr_reset");
    exp_wr_addr.delete(); exp_wr_data.delete(); exp_rd_addr.delete(); rd_pend.delete();
    prev_stall = 0; wr_off = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run_test(2, AW'(32'h7FFFFFE), 32'h0F0F0001, 0, -1, 0);
    run_test(0, AW'(32'h10), 32'h00000001, 0, -1, 0);

    // Stray read beat while idle
    #1 inject = 1;
    repeat (3) @(negedge clk);
    check("idle_unexpected_beat", DW'(err_count), DW'(1));
    check("idle_pass_held", DW'(pass), DW'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
